// File: rtl/tcp_rx_seq_trimmer.sv
// rtl/tcp_rx_seq_trimmer.sv - tags TCP payload bytes with seq numbers, trims out-of-window bytes, emits contiguous runs
module tcp_rx_seq_trimmer #(
  parameter int SEQ_BITS = 32,
  parameter int WINDOW   = 64,
  parameter int CNT_BITS = 16
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                hdr_valid,
  input  logic [SEQ_BITS-1:0] hdr_seq,
  input  logic                hdr_syn,
  input  logic [CNT_BITS-1:0] hdr_len,
  output logic                hdr_ready,
  input  logic [7:0]          s_axis_tdata,
  input  logic                s_axis_tvalid,
  output logic                s_axis_tready,
  input  logic                s_axis_tlast,
  output logic [7:0]          m_axis_tdata,
  output logic                m_axis_tvalid,
  input  logic                m_axis_tready,
  output logic [SEQ_BITS-1:0] seq_start,
  output logic [SEQ_BITS-1:0] seq_base,
  output logic                base_valid,
  input  logic [SEQ_BITS-1:0] ack_in,
  output logic                len_err,
  output logic [CNT_BITS-1:0] drop_cnt
);

  typedef enum logic [1:0] {S_IDLE, S_BASE, S_SETTLE, S_XFER} state_t;

  localparam logic [SEQ_BITS-1:0] SEQ_ONE = 1;
  localparam logic [CNT_BITS-1:0] CNT_ONE = 1;
  localparam logic [SEQ_BITS-1:0] WIN_LIM = SEQ_BITS'(WINDOW);

  state_t              r_state;
  logic                r_synced;
  logic [SEQ_BITS-1:0] r_cur_seq;
  logic [SEQ_BITS-1:0] r_exp_seq;
  logic [SEQ_BITS-1:0] r_seq_start;
  logic [SEQ_BITS-1:0] r_seq_base;
  logic [CNT_BITS-1:0] r_rem;
  logic [CNT_BITS-1:0] r_drop_cnt;
  logic                r_base_valid;
  logic                r_len_err;

  logic [SEQ_BITS-1:0] w_off;
  logic [SEQ_BITS-1:0] w_syn_inc;
  logic                w_in_win;
  logic                w_restart_block;
  logic                w_keep;
  logic                w_xfer;
  logic                w_drop;
  logic                w_jump;
  logic                w_pass;
  logic                w_consume;
  logic                w_rem_last;
  logic                w_seg_end;

  // Distance ahead of the ack point; negative (MSB set) means already acked.
  assign w_off      = r_cur_seq - ack_in;
  assign w_in_win   = !w_off[SEQ_BITS-1] && (w_off < WIN_LIM);
  // Restarting a run at the current seq_start would not be seen as a new run downstream.
  assign w_restart_block = (r_cur_seq == r_seq_start) && (r_exp_seq != r_seq_start);
  assign w_keep     = r_synced && w_in_win && !w_restart_block;
  assign w_xfer     = (r_state == S_XFER);
  assign w_drop     = w_xfer && !w_keep;
  assign w_jump     = w_xfer && w_keep && (r_cur_seq != r_exp_seq);
  assign w_pass     = w_xfer && w_keep && (r_cur_seq == r_exp_seq);
  assign w_consume  = s_axis_tvalid && s_axis_tready;
  assign w_rem_last = (r_rem == CNT_ONE);
  assign w_seg_end  = w_consume && (s_axis_tlast || w_rem_last);
  assign w_syn_inc  = {{(SEQ_BITS-1){1'b0}}, hdr_syn};

  assign hdr_ready     = (r_state == S_IDLE);
  assign m_axis_tdata  = s_axis_tdata;
  assign m_axis_tvalid = w_pass && s_axis_tvalid;
  assign s_axis_tready = w_drop || (w_pass && m_axis_tready);
  assign seq_start     = r_seq_start;
  assign seq_base      = r_seq_base;
  assign base_valid    = r_base_valid;
  assign len_err       = r_len_err;
  assign drop_cnt      = r_drop_cnt;

  // Segment FSM: header capture, SYN anchoring, run restart settle and per-byte trimming.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= S_IDLE;
      r_synced     <= 1'b0;
      r_cur_seq    <= '0;
      r_exp_seq    <= '0;
      r_seq_start  <= '0;
      r_seq_base   <= '0;
      r_rem        <= '0;
      r_drop_cnt   <= '0;
      r_base_valid <= 1'b0;
      r_len_err    <= 1'b0;
    end else begin
      r_base_valid <= 1'b0;
      r_len_err    <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (hdr_valid) begin
            r_cur_seq <= hdr_seq + w_syn_inc;
            r_rem     <= hdr_len;
            if (hdr_syn) begin
              // Anchor registers load on entry so they are already valid during BASE.
              r_state      <= S_BASE;
              r_base_valid <= 1'b1;
              r_seq_base   <= hdr_seq + SEQ_ONE;
              r_seq_start  <= hdr_seq + SEQ_ONE;
              r_exp_seq    <= hdr_seq + SEQ_ONE;
              r_synced     <= 1'b1;
            end else if (hdr_len == '0) begin
              r_state <= S_IDLE;
            end else begin
              r_state <= S_XFER;
            end
          end
        end
        S_BASE: begin
          r_state <= S_SETTLE;
        end
        S_SETTLE: begin
          r_state <= (r_rem == '0) ? S_IDLE : S_XFER;
        end
        S_XFER: begin
          if (w_jump) begin
            r_seq_start <= r_cur_seq;
            r_exp_seq   <= r_cur_seq;
            r_state     <= S_SETTLE;
          end else if (w_consume) begin
            r_cur_seq <= r_cur_seq + SEQ_ONE;
            r_rem     <= r_rem - CNT_ONE;
            if (w_pass) begin
              r_exp_seq <= r_exp_seq + SEQ_ONE;
            end
            if (w_drop && (r_drop_cnt != '1)) begin
              r_drop_cnt <= r_drop_cnt + CNT_ONE;
            end
            if (w_seg_end) begin
              r_state   <= S_IDLE;
              r_len_err <= (s_axis_tlast != w_rem_last);
            end
          end
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_tcp_rx_seq_trimmer.sv
// tb/tb_tcp_rx_seq_trimmer.sv - directed self-checking bench for tcp_rx_seq_trimmer
module tb_tcp_rx_seq_trimmer;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        hdr_valid;
  logic [31:0] hdr_seq;
  logic        hdr_syn;
  logic [15:0] hdr_len;
  logic        hdr_ready;
  logic [7:0]  s_axis_tdata;
  logic        s_axis_tvalid;
  logic        s_axis_tready;
  logic        s_axis_tlast;
  logic [7:0]  m_axis_tdata;
  logic        m_axis_tvalid;
  logic        m_axis_tready;
  logic [31:0] seq_start;
  logic [31:0] seq_base;
  logic        base_valid;
  logic [31:0] ack_in;
  logic        len_err;
  logic [15:0] drop_cnt;

  int   n_cmp = 0;
  int   n_err = 0;
  int   fwd;
  int   drp;
  int   stalls;
  logic mvalid_any;

  always #5 clk = ~clk;

  tcp_rx_seq_trimmer dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .hdr_valid     (hdr_valid),
    .hdr_seq       (hdr_seq),
    .hdr_syn       (hdr_syn),
    .hdr_len       (hdr_len),
    .hdr_ready     (hdr_ready),
    .s_axis_tdata  (s_axis_tdata),
    .s_axis_tvalid (s_axis_tvalid),
    .s_axis_tready (s_axis_tready),
    .s_axis_tlast  (s_axis_tlast),
    .m_axis_tdata  (m_axis_tdata),
    .m_axis_tvalid (m_axis_tvalid),
    .m_axis_tready (m_axis_tready),
    .seq_start     (seq_start),
    .seq_base      (seq_base),
    .base_valid    (base_valid),
    .ack_in        (ack_in),
    .len_err       (len_err),
    .drop_cnt      (drop_cnt)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // SYN with no payload: one-cycle base_valid pulse, anchor = seq+1, back to IDLE after SETTLE.
  task automatic do_syn(input logic [31:0] seq);
    logic [31:0] anchor;
    anchor = seq + 32'd1;
    @(negedge clk);
    hdr_valid = 1'b1; hdr_seq = seq; hdr_syn = 1'b1; hdr_len = 16'd0;
    @(negedge clk);
    hdr_valid = 1'b0; hdr_syn = 1'b0;
    #1;
    check("syn_base_valid_hi", 32'(base_valid), 32'd1);
    check("syn_seq_base", seq_base, anchor);
    check("syn_seq_start", seq_start, anchor);
    check("syn_hdr_ready_lo", 32'(hdr_ready), 32'd0);
    @(negedge clk);
    #1;
    check("syn_base_valid_lo", 32'(base_valid), 32'd0);
    @(negedge clk);
    #1;
    check("syn_back_idle", 32'(hdr_ready), 32'd1);
  endtask

  // Header then nbytes payload bytes; tallies forwarded/dropped bytes and stall cycles.
  task automatic run_seg(input logic [31:0] seq, input logic [15:0] len,
                         input int nbytes, input int last_at);
    logic got;
    fwd = 0; drp = 0; stalls = 0; mvalid_any = 1'b0;
    @(negedge clk);
    hdr_valid = 1'b1; hdr_seq = seq; hdr_syn = 1'b0; hdr_len = len;
    @(negedge clk);
    hdr_valid = 1'b0;
    for (int i = 0; i < nbytes; i++) begin
      s_axis_tvalid = 1'b1;
      s_axis_tdata  = 8'(i + 48);
      s_axis_tlast  = (i == last_at);
      got = 1'b0;
      for (int w = 0; w < 20 && !got; w++) begin
        #1;
        if (m_axis_tvalid) mvalid_any = 1'b1;
        if (s_axis_tready) begin
          got = 1'b1;
          if (m_axis_tvalid) begin
            fwd++;
            check("tdata_pass", 32'(m_axis_tdata), 32'(s_axis_tdata));
          end else begin
            drp++;
          end
        end else begin
          stalls++;
        end
        @(negedge clk);
      end
      check("byte_accepted_in_time", 32'(got), 32'd1);
    end
    s_axis_tvalid = 1'b0;
    s_axis_tlast  = 1'b0;
    #1;
  endtask

  initial begin
    rst_n = 1'b0; hdr_valid = 1'b0; hdr_seq = '0; hdr_syn = 1'b0; hdr_len = '0;
    s_axis_tdata = '0; s_axis_tvalid = 1'b0; s_axis_tlast = 1'b0;
    m_axis_tready = 1'b1; ack_in = '0;
    repeat (2) @(negedge clk);
    #1;
    check("rst_m_tvalid", 32'(m_axis_tvalid), 32'd0);
    check("rst_s_tready", 32'(s_axis_tready), 32'd0);
    check("rst_base_valid", 32'(base_valid), 32'd0);
    check("rst_seq_start", seq_start, 32'd0);
    check("rst_seq_base", seq_base, 32'd0);
    check("rst_len_err", 32'(len_err), 32'd0);
    check("rst_drop_cnt", 32'(drop_cnt), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // Before any SYN every byte is dropped.
    run_seg(32'h0, 16'd2, 2, 1);
    check("unsync_drop", 32'(drp), 32'd2);
    check("unsync_fwd", 32'(fwd), 32'd0);
    check("unsync_mvalid", 32'(mvalid_any), 32'd0);
    check("unsync_drop_cnt", 32'(drop_cnt), 32'd2);

    do_syn(32'h100);

    // In-order segment right at the anchor: no settle, four bytes forwarded.
    ack_in = 32'h101;
    run_seg(32'h101, 16'd4, 4, 3);
    check("inorder_fwd", 32'(fwd), 32'd4);
    check("inorder_stalls", 32'(stalls), 32'd0);
    check("inorder_drop", 32'(drp), 32'd0);
    check("inorder_seq_start", seq_start, 32'h101);
    check("inorder_idle", 32'(hdr_ready), 32'd1);
    run_seg(32'h105, 16'd1, 1, 0);
    check("contig_fwd", 32'(fwd), 32'd1);
    check("contig_stalls", 32'(stalls), 32'd0);
    check("contig_seq_start", seq_start, 32'h101);

    // Overlap with acked data: two dropped, run restarts at 0x101 through SETTLE.
    do_syn(32'h0F0);
    run_seg(32'h0FF, 16'd4, 4, 3);
    check("trim_drop", 32'(drp), 32'd2);
    check("trim_fwd", 32'(fwd), 32'd2);
    check("trim_settle_stalls", 32'(stalls), 32'd2);
    check("trim_seq_start", seq_start, 32'h101);
    check("trim_drop_cnt", 32'(drop_cnt), 32'd4);

    // First byte exactly WINDOW past ack: all out of window.
    run_seg(32'h141, 16'd3, 3, 2);
    check("win_drop", 32'(drp), 32'd3);
    check("win_mvalid", 32'(mvalid_any), 32'd0);
    check("win_drop_cnt", 32'(drop_cnt), 32'd7);
    check("win_seq_start", seq_start, 32'h101);

    // Sequence wrap.
    do_syn(32'hFFFF_FFFD);
    ack_in = 32'hFFFF_FFFE;
    run_seg(32'hFFFF_FFFE, 16'd4, 4, 3);
    check("wrap_fwd", 32'(fwd), 32'd4);
    check("wrap_stalls", 32'(stalls), 32'd0);
    check("wrap_seq_start", seq_start, 32'hFFFF_FFFE);
    run_seg(32'h2, 16'd1, 1, 0);
    check("wrap_exp_fwd", 32'(fwd), 32'd1);
    check("wrap_exp_stalls", 32'(stalls), 32'd0);

    // Early tlast with back-pressure mid-run.
    @(negedge clk);
    hdr_valid = 1'b1; hdr_seq = 32'h3; hdr_len = 16'd5;
    @(negedge clk);
    hdr_valid = 1'b0;
    s_axis_tvalid = 1'b1; s_axis_tdata = 8'hA0; s_axis_tlast = 1'b0; m_axis_tready = 1'b1;
    #1;
    check("bp_b0_ready", 32'(s_axis_tready), 32'd1);
    check("bp_b0_valid", 32'(m_axis_tvalid), 32'd1);
    @(negedge clk);
    s_axis_tdata = 8'hA1; m_axis_tready = 1'b0;
    #1;
    check("bp_hold_ready_lo", 32'(s_axis_tready), 32'd0);
    check("bp_hold_valid", 32'(m_axis_tvalid), 32'd1);
    @(negedge clk);
    m_axis_tready = 1'b1;
    #1;
    check("bp_release_ready", 32'(s_axis_tready), 32'd1);
    check("bp_release_data", 32'(m_axis_tdata), 32'hA1);
    @(negedge clk);
    s_axis_tdata = 8'hA2; s_axis_tlast = 1'b1;
    #1;
    check("bp_b2_ready", 32'(s_axis_tready), 32'd1);
    check("lenerr_not_yet", 32'(len_err), 32'd0);
    @(negedge clk);
    s_axis_tvalid = 1'b0; s_axis_tlast = 1'b0;
    #1;
    check("lenerr_pulse", 32'(len_err), 32'd1);
    check("lenerr_idle", 32'(hdr_ready), 32'd1);
    @(negedge clk);
    #1;
    check("lenerr_one_cycle", 32'(len_err), 32'd0);
    run_seg(32'h6, 16'd1, 1, 0);
    check("no_loss_fwd", 32'(fwd), 32'd1);
    check("no_loss_stalls", 32'(stalls), 32'd0);

    // hdr_len reached without tlast.
    run_seg(32'h7, 16'd2, 2, -1);
    check("nolast_fwd", 32'(fwd), 32'd2);
    check("nolast_len_err", 32'(len_err), 32'd1);

    // Reset mid-segment clears everything including sync.
    run_seg(32'h9, 16'd3, 1, -1);
    check("midseg_busy", 32'(hdr_ready), 32'd0);
    s_axis_tvalid = 1'b1;
    rst_n = 1'b0;
    #1;
    check("midrst_s_tready", 32'(s_axis_tready), 32'd0);
    check("midrst_seq_start", seq_start, 32'd0);
    check("midrst_seq_base", seq_base, 32'd0);
    check("midrst_drop_cnt", 32'(drop_cnt), 32'd0);
    check("midrst_idle", 32'(hdr_ready), 32'd1);
    @(negedge clk);
    rst_n = 1'b1; s_axis_tvalid = 1'b0; ack_in = 32'h0;
    run_seg(32'h0, 16'd1, 1, 0);
    check("postrst_unsync_drop", 32'(drp), 32'd1);
    check("postrst_unsync_fwd", 32'(fwd), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
